hdmi_rx_align_ctrl: RTL and testbench
=====================================

HDMI_RX_ALIGN_CTRL -- requirements
Module: hdmi_rx_align_ctrl

Interface
REQ-001 SHALL have parameter SEARCH_WORDS, default 1024: valid words observed per slip position before slipping.
REQ-002 SHALL have parameter SLIP_SETTLE, default 4: clk cycles ignored after each bitslip pulse.
REQ-003 SHALL have parameter LOCK_TOKENS, default 16: consecutive control tokens required to declare lock.
REQ-004 SHALL have parameter LOSS_WORDS, default 4096: consecutive non-token valid words that drop lock.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enable  input  1  level; 1 runs alignment, 0 forces IDLE.
REQ-008 SHALL have port word_valid  input  1  qualifies tmds_word for one cycle.
REQ-009 SHALL have port tmds_word  input  10  raw deserialized TMDS word from one channel.
REQ-010 SHALL have port bitslip  output  1  one-cycle pulse commanding the deserializer to slip one bit.
REQ-011 SHALL have port locked  output  1  registered; 1 while in LOCKED.
REQ-012 SHALL have port slip_count  output  4  current slip position, 0..9.
REQ-013 SHALL have port align_err  output  1  sticky; set when all 10 positions fail.
REQ-014 SHALL have port token_seen  output  1  one-cycle pulse, registered, per valid control-token word.

Function
REQ-015 Control tokens SHALL be exactly 10'h354, 10'h0AB, 10'h154, 10'h2AB; every other value is a non-token.
REQ-016 The FSM SHALL have states IDLE, SEARCH, SLIP, SETTLE, LOCKED.
REQ-017 From any state, enable=0 SHALL move to IDLE next cycle, clearing locked, align_err, slip_count and all counters.
REQ-018 IDLE with enable=1 SHALL go to SEARCH next cycle with word_cnt=0 and run_cnt=0.
REQ-019 In SEARCH, each valid word SHALL increment word_cnt; a token increments run_cnt, a non-token clears run_cnt to 0.
REQ-020 In SEARCH, when run_cnt reaches LOCK_TOKENS, the FSM SHALL enter LOCKED and locked SHALL be 1 the cycle after that word is sampled.
REQ-021 In SEARCH, when word_cnt reaches SEARCH_WORDS without lock, the FSM SHALL enter SLIP; if both conditions occur on the same word, lock wins.
REQ-022 SLIP SHALL last one cycle with bitslip=1, increment slip_count modulo 10, then enter SETTLE.
REQ-023 On a slip_count wrap 9->0, align_err SHALL be set and held until enable=0 or reset; search continues.
REQ-024 SETTLE SHALL last exactly SLIP_SETTLE clk cycles regardless of word_valid, ignore all words, then enter SEARCH with word_cnt=run_cnt=0.
REQ-025 In LOCKED, a valid token SHALL clear loss_cnt; a valid non-token increments it.
REQ-026 In LOCKED, when loss_cnt reaches LOSS_WORDS, the FSM SHALL enter SEARCH with counters cleared, slip_count retained, and locked=0 the following cycle.
REQ-027 bitslip SHALL never assert outside SLIP and SHALL never assert on consecutive cycles.
REQ-028 token_seen SHALL pulse in every state except IDLE and SETTLE for each valid token word, one cycle after sampling.
REQ-029 Counters SHALL be sized by $clog2 of their parameter plus 1 and SHALL saturate, never wrap.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, bitslip=0, locked=0, slip_count=0, align_err=0, token_seen=0, all counters 0.
REQ-031 After rst_n release with enable=1, the FSM SHALL enter SEARCH on the first clk edge.

Verification
REQ-032 Aligned stream: enable=1, 16 consecutive valid 10'h354 -> locked=1 one cycle after the 16th word, bitslip never pulses, slip_count=0.
REQ-033 Stream rotated 3 bits, bench model rotates one bit per bitslip -> exactly 3 bitslip pulses, each at least SEARCH_WORDS+SLIP_SETTLE+1 cycles apart, then locked=1 with slip_count=3, align_err=0.
REQ-034 Continuous 10'h1F0 only -> 10 bitslip pulses, slip_count returns to 0, align_err=1 after the 10th, locked stays 0.
REQ-035 Run broken: 15 tokens, one 10'h1F0, 16 tokens -> locked=0 after the first run, locked=1 one cycle after the 32nd token word.
REQ-036 Locked, then 4096 valid 10'h1F0 -> locked=0 one cycle after the 4096th word; next bitslip only after a further 1024 non-token words.
REQ-037 rst_n low during SETTLE -> all outputs 0 that same cycle; after release with enable=1 the FSM returns to SEARCH with slip_count=0.

Source files
------------

// File: rtl/hdmi_rx_align_ctrl.sv
// TMDS word aligner: steps the deserializer one bit at a time until a run of control tokens is found.
// Latency: outputs are registered, one cycle after the sampled word. Backpressure: none; words are sampled only when word_valid is high.
module hdmi_rx_align_ctrl #(
  parameter int SEARCH_WORDS = 1024,
  parameter int SLIP_SETTLE  = 4,
  parameter int LOCK_TOKENS  = 16,
  parameter int LOSS_WORDS   = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       word_valid,
  input  logic [9:0] tmds_word,
  output logic       bitslip,
  output logic       locked,
  output logic [3:0] slip_count,
  output logic       align_err,
  output logic       token_seen
);

  localparam int WCW = $clog2(SEARCH_WORDS) + 1;
  localparam int SCW = $clog2(SLIP_SETTLE) + 1;
  localparam int RCW = $clog2(LOCK_TOKENS) + 1;
  localparam int LCW = $clog2(LOSS_WORDS) + 1;

  localparam logic [WCW-1:0] WORD_MAX   = WCW'(SEARCH_WORDS);
  localparam logic [SCW-1:0] SETTLE_MAX = SCW'(SLIP_SETTLE);
  localparam logic [RCW-1:0] RUN_MAX    = RCW'(LOCK_TOKENS);
  localparam logic [LCW-1:0] LOSS_MAX   = LCW'(LOSS_WORDS);

  typedef enum logic [2:0] {IDLE, SEARCH, SLIP, SETTLE, LOCKED} state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d, word_inc;
  logic [SCW-1:0] settle_cnt_q, settle_cnt_d, settle_inc;
  logic [RCW-1:0] run_cnt_q, run_cnt_d, run_inc;
  logic [LCW-1:0] loss_cnt_q, loss_cnt_d, loss_inc;
  logic [3:0]     slip_count_q, slip_count_d;
  logic           bitslip_q, bitslip_d;
  logic           locked_q, locked_d;
  logic           align_err_q, align_err_d;
  logic           token_seen_q, token_seen_d;
  logic           is_token, tok_vld;

  assign is_token = (tmds_word == 10'h354) || (tmds_word == 10'h0AB) ||
                    (tmds_word == 10'h154) || (tmds_word == 10'h2AB);
  assign tok_vld  = word_valid && is_token;

  // All counters hold at their terminal value instead of wrapping.
  assign word_inc   = (word_cnt_q == WORD_MAX)     ? word_cnt_q   : word_cnt_q + WCW'(1);
  assign settle_inc = (settle_cnt_q == SETTLE_MAX) ? settle_cnt_q : settle_cnt_q + SCW'(1);
  assign run_inc    = (run_cnt_q == RUN_MAX)       ? run_cnt_q    : run_cnt_q + RCW'(1);
  assign loss_inc   = (loss_cnt_q == LOSS_MAX)     ? loss_cnt_q   : loss_cnt_q + LCW'(1);

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    settle_cnt_d = settle_cnt_q;
    run_cnt_d    = run_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    slip_count_d = slip_count_q;
    locked_d     = locked_q;
    align_err_d  = align_err_q;
    bitslip_d    = 1'b0;
    token_seen_d = tok_vld && ((state_q == SEARCH) || (state_q == SLIP) || (state_q == LOCKED));

    if (!enable) begin
      state_d      = IDLE;
      word_cnt_d   = '0;
      settle_cnt_d = '0;
      run_cnt_d    = '0;
      loss_cnt_d   = '0;
      slip_count_d = 4'd0;
      locked_d     = 1'b0;
      align_err_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = SEARCH;
          word_cnt_d = '0;
          run_cnt_d  = '0;
        end
        SEARCH: begin
          if (word_valid) begin
            word_cnt_d = word_inc;
            run_cnt_d  = is_token ? run_inc : '0;
            // A lock on the same word that exhausts the search window takes priority.
            if (is_token && (run_inc == RUN_MAX)) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              loss_cnt_d = '0;
            end else if (word_inc == WORD_MAX) begin
              state_d   = SLIP;
              bitslip_d = 1'b1;
            end
          end
        end
        SLIP: begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
          if (slip_count_q == 4'd9) begin
            slip_count_d = 4'd0;
            align_err_d  = 1'b1;
          end else begin
            slip_count_d = slip_count_q + 4'd1;
          end
        end
        SETTLE: begin
          if (settle_inc == SETTLE_MAX) begin
            state_d      = SEARCH;
            settle_cnt_d = '0;
            word_cnt_d   = '0;
            run_cnt_d    = '0;
          end else begin
            settle_cnt_d = settle_inc;
          end
        end
        LOCKED: begin
          if (word_valid) begin
            if (is_token) begin
              loss_cnt_d = '0;
            end else if (loss_inc == LOSS_MAX) begin
              state_d    = SEARCH;
              locked_d   = 1'b0;
              loss_cnt_d = '0;
              word_cnt_d = '0;
              run_cnt_d  = '0;
            end else begin
              loss_cnt_d = loss_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      settle_cnt_q <= '0;
      run_cnt_q    <= '0;
      loss_cnt_q   <= '0;
      slip_count_q <= 4'd0;
      bitslip_q    <= 1'b0;
      locked_q     <= 1'b0;
      align_err_q  <= 1'b0;
      token_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      run_cnt_q    <= run_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      slip_count_q <= slip_count_d;
      bitslip_q    <= bitslip_d;
      locked_q     <= locked_d;
      align_err_q  <= align_err_d;
      token_seen_q <= token_seen_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign locked     = locked_q;
  assign slip_count = slip_count_q;
  assign align_err  = align_err_q;
  assign token_seen = token_seen_q;

endmodule

// File: tb/tb_hdmi_rx_align_ctrl.sv
// Bench for hdmi_rx_align_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_hdmi_rx_align_ctrl;
  localparam int SW = 1024;
  localparam int SS = 4;
  localparam int LT = 16;
  localparam int LW = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       word_valid = 1'b0;
  logic [9:0] tmds_word = 10'h000;
  logic       bitslip, locked, align_err, token_seen;
  logic [3:0] slip_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  always #5 clk = ~clk;

  hdmi_rx_align_ctrl #(.SEARCH_WORDS(SW), .SLIP_SETTLE(SS), .LOCK_TOKENS(LT), .LOSS_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .word_valid(word_valid), .tmds_word(tmds_word),
    .bitslip(bitslip), .locked(locked), .slip_count(slip_count), .align_err(align_err),
    .token_seen(token_seen)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic bit is_ctrl(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int k);
    logic [19:0] d;
    d = {w, w} << k;
    return d[19:10];
  endfunction

  // Behavioural model: what the aligner is doing, tracked as plain integers.
  bit m_active, m_slip_now, m_locked, m_err, m_tok, m_bitslip;
  int m_settle, m_words, m_run, m_loss, m_pos;

  task automatic model_reset();
    m_active = 0; m_slip_now = 0; m_locked = 0; m_err = 0; m_tok = 0; m_bitslip = 0;
    m_settle = 0; m_words = 0; m_run = 0; m_loss = 0; m_pos = 0;
  endtask

  task automatic model_step();
    bit tok, listen;
    tok    = word_valid && is_ctrl(tmds_word);
    listen = m_active && (m_settle == 0);
    m_tok  = tok && listen;
    if (!enable) begin
      model_reset();
      m_tok = tok && listen;
    end else if (!m_active) begin
      m_active = 1; m_words = 0; m_run = 0;
    end else if (m_slip_now) begin
      m_slip_now = 0;
      m_pos = (m_pos + 1) % 10;
      if (m_pos == 0) m_err = 1;
      m_settle = SS;
    end else if (m_settle > 0) begin
      m_settle--;
      if (m_settle == 0) begin m_words = 0; m_run = 0; end
    end else if (m_locked) begin
      if (word_valid) begin
        if (tok) m_loss = 0;
        else begin
          m_loss++;
          if (m_loss == LW) begin m_locked = 0; m_words = 0; m_run = 0; m_loss = 0; end
        end
      end
    end else if (word_valid) begin
      m_words++;
      m_run = tok ? m_run + 1 : 0;
      if (m_run == LT) begin m_locked = 1; m_loss = 0; end
      else if (m_words == SW) m_slip_now = 1;
    end
    m_bitslip = m_slip_now;
  endtask

  // Single model+compare process: advance the model on each edge, compare just after it.
  initial begin
    bit prev_bs;
    prev_bs = 0;
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else model_step();
      #1;
      chk("bitslip", bitslip, m_bitslip);
      chk("locked", locked, m_locked);
      chk("slip_count", slip_count, m_pos);
      chk("align_err", align_err, m_err);
      chk("token_seen", token_seen, m_tok);
      chk("bitslip_back_to_back", bitslip & prev_bs, 0);
      prev_bs = bitslip;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time budget expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic step(input bit en, input bit v, input logic [9:0] w);
    @(negedge clk);
    enable = en; word_valid = v; tmds_word = w;
    @(posedge clk);
    #2;
  endtask

  task automatic go_idle_then_search();
    step(0, 0, 10'h000);
    step(0, 0, 10'h000);
    step(1, 0, 10'h000);
  endtask

  initial begin
    int nsl, last, early, p;
    bit v;
    logic [9:0] w;

    // Reset state
    #3 rst_n = 1'b0;
    #1;
    chk("rst_bitslip", bitslip, 0);
    chk("rst_locked", locked, 0);
    chk("rst_slip_count", slip_count, 0);
    chk("rst_align_err", align_err, 0);
    chk("rst_token_seen", token_seen, 0);
    repeat (2) @(posedge clk);

    // Aligned stream: release with enable high, first edge enters search
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1; word_valid = 1'b0;
    @(posedge clk); #2;
    nsl = 0;
    for (int i = 1; i <= LT; i++) begin
      step(1, 1, 10'h354);
      if (bitslip) nsl++;
      if (i == 1)  chk("A_token_seen", token_seen, 1);
      if (i == LT - 1) chk("A_locked_early", locked, 0);
      if (i == LT) begin
        chk("A_locked", locked, 1);
        chk("A_model_locked", m_locked, 1);
      end
    end
    chk("A_no_bitslip", nsl, 0);
    chk("A_slip_count", slip_count, 0);

    // Stream rotated by 3 bits; the deserializer model undoes one bit per pulse
    go_idle_then_search();
    nsl = 0; last = -1;
    for (int i = 0; i < 8000 && !locked; i++) begin
      v = ($urandom_range(0, 9) < 8);
      step(1, v, rotl(10'h354, (7 + nsl) % 10));
      if (bitslip) begin
        if (last >= 0) chk("B_gap_ok", (cyc - last) >= (SW + SS + 1), 1);
        last = cyc;
        nsl++;
      end
    end
    chk("B_locked", locked, 1);
    chk("B_pulses", nsl, 3);
    chk("B_slip_count", slip_count, 3);
    chk("B_align_err", align_err, 0);

    // No token anywhere: all ten positions fail
    go_idle_then_search();
    nsl = 0;
    for (int i = 0; i < 12000 && nsl < 10; i++) begin
      step(1, 1, 10'h1F0);
      if (bitslip) begin
        nsl++;
        if (nsl == 10) begin
          chk("C_pos_before_wrap", slip_count, 9);
          chk("C_err_before_wrap", align_err, 0);
        end
      end
    end
    chk("C_pulses", nsl, 10);
    step(1, 1, 10'h1F0);
    chk("C_slip_wrapped", slip_count, 0);
    chk("C_align_err", align_err, 1);
    chk("C_model_err", m_err, 1);
    repeat (10) step(1, 1, 10'h1F0);
    chk("C_err_sticky", align_err, 1);
    chk("C_not_locked", locked, 0);

    // Broken run then a full run
    go_idle_then_search();
    for (int i = 1; i <= 32; i++) begin
      w = (i == 16) ? 10'h1F0 : toks[$urandom_range(0, 3)];
      step(1, 1, w);
      if (i == 15) chk("D_locked_after_15", locked, 0);
      if (i == 31) chk("D_locked_after_31", locked, 0);
      if (i == 32) begin
        chk("D_locked_after_32", locked, 1);
        chk("D_model_locked", m_locked, 1);
      end
    end

    // Loss of lock, then a fresh search window before the next slip
    for (int i = 1; i <= LW; i++) begin
      step(1, 1, 10'h1F0);
      if (i == LW - 1) chk("E_still_locked", locked, 1);
      if (i == LW)     chk("E_lock_lost", locked, 0);
    end
    early = 0;
    for (int i = 1; i <= SW; i++) begin
      step(1, 1, 10'h1F0);
      if (i < SW && bitslip) early++;
      if (i == SW) chk("E_slip_after_window", bitslip, 1);
    end
    chk("E_no_early_slip", early, 0);

    // Reset asserted while settling
    step(1, 0, 10'h000);
    chk("F_pre_slip_count", slip_count, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("F_rst_bitslip", bitslip, 0);
    chk("F_rst_locked", locked, 0);
    chk("F_rst_slip_count", slip_count, 0);
    chk("F_rst_align_err", align_err, 0);
    chk("F_rst_token_seen", token_seen, 0);
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1; word_valid = 1'b0;
    @(posedge clk); #2;
    for (int i = 1; i <= LT; i++) step(1, 1, 10'h0AB);
    chk("F_relock", locked, 1);
    chk("F_relock_pos", slip_count, 0);

    // Random traffic in segments of varying token density
    p = 95;
    for (int i = 0; i < 4000; i++) begin
      if (i % 300 == 0) p = (i % 900 == 0) ? 95 : ((i % 600 == 0) ? 10 : 70);
      v = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 99) < p) ? toks[$urandom_range(0, 3)] : 10'($urandom_range(0, 1023));
      step($urandom_range(0, 199) != 0, v, w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
